// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN-policy car controller with registered outputs.
// Optional ELEVATOR_REOPEN_EN: a call at the current floor reopens a closing door.
module elevator_ctrl #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_W       = 3,
  parameter int DOOR_HOLD     = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] buttons,
  input  logic                     sensor_up,
  input  logic                     sensor_down,
  input  logic [1:0]               sensor_door,
  output logic [1:0]               engine,
  output logic [1:0]               door,
  output logic [FLOOR_W-1:0]       floor,
  output logic [BUTTONS_WIDTH-1:0] requests
);

  localparam int CNT_W = $clog2(DOOR_HOLD + 1);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(BUTTONS_WIDTH - 1);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(DOOR_HOLD);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  localparam logic [1:0] ENG_STOP = 2'b00;
  localparam logic [1:0] ENG_UP   = 2'b01;
  localparam logic [1:0] ENG_DN   = 2'b10;
  localparam logic [1:0] DR_IDLE  = 2'b00;
  localparam logic [1:0] DR_OPEN  = 2'b01;
  localparam logic [1:0] DR_CLOSE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_OPEN,
    S_HOLD,
    S_CLOSE
  } state_t;

  state_t                   r_state, w_state;
  logic [1:0]               r_engine, w_engine;
  logic [1:0]               r_door, w_door;
  logic [FLOOR_W-1:0]       r_floor, w_floor;
  logic [BUTTONS_WIDTH-1:0] r_req, w_req;
  logic                     r_dir_up, w_dir_up;
  logic [CNT_W-1:0]         r_cnt, w_cnt;

  logic [BUTTONS_WIDTH-1:0] w_cur;
  logic [BUTTONS_WIDTH-1:0] w_set;
  logic [BUTTONS_WIDTH-1:0] w_clr;
  logic                     w_above;
  logic                     w_below;

  // Pending-call summary relative to the current floor.
  always_comb begin
    w_cur   = BUTTONS_WIDTH'(1) << r_floor;
    w_above = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      if (r_req[i] && (i > int'(r_floor))) w_above = 1'b1;
      if (r_req[i] && (i < int'(r_floor))) w_below = 1'b1;
    end
  end

  // Next state, next registered outputs and call latch/clear.
  always_comb begin
    w_state  = r_state;
    w_engine = r_engine;
    w_door   = r_door;
    w_floor  = r_floor;
    w_dir_up = r_dir_up;
    w_cnt    = r_cnt;
    w_set    = buttons;
    w_clr    = '0;
    unique case (r_state)
      S_IDLE: begin
        w_engine = ENG_STOP;
        w_door   = DR_IDLE;
        if (|(r_req & w_cur)) begin
          w_state = S_OPEN;
          w_door  = DR_OPEN;
        end else if (w_above && (r_dir_up || !w_below)) begin
          w_state  = S_UP;
          w_engine = ENG_UP;
          w_dir_up = 1'b1;
        end else if (w_below) begin
          w_state  = S_DOWN;
          w_engine = ENG_DN;
          w_dir_up = 1'b0;
        end
      end
      S_UP: begin
        if (sensor_up) begin
          if (r_floor == TOP) begin
            w_engine = ENG_STOP;
            w_state  = S_IDLE;
          end else begin
            w_floor = r_floor + FLOOR_W'(1);
            if (r_req[w_floor]) begin
              w_engine = ENG_STOP;
              w_door   = DR_OPEN;
              w_state  = S_OPEN;
            end
          end
        end
      end
      S_DOWN: begin
        if (sensor_down) begin
          if (r_floor == '0) begin
            w_engine = ENG_STOP;
            w_state  = S_IDLE;
          end else begin
            w_floor = r_floor - FLOOR_W'(1);
            if (r_req[w_floor]) begin
              w_engine = ENG_STOP;
              w_door   = DR_OPEN;
              w_state  = S_OPEN;
            end
          end
        end
      end
      S_OPEN: begin
        if (sensor_door == DR_OPEN) begin
          w_clr   = w_cur;
          w_door  = DR_IDLE;
          w_cnt   = HOLD;
          w_state = S_HOLD;
        end
      end
      S_HOLD: begin
        w_set = buttons & ~w_cur;
        if (buttons[r_floor]) begin
          w_cnt = HOLD;
        end else if (r_cnt == ONE) begin
          w_cnt   = '0;
          w_door  = DR_CLOSE;
          w_state = S_CLOSE;
        end else begin
          w_cnt = r_cnt - ONE;
        end
      end
      S_CLOSE: begin
`ifdef ELEVATOR_REOPEN_EN
        w_set = buttons & ~w_cur;
        if (buttons[r_floor]) begin
          w_door  = DR_OPEN;
          w_state = S_OPEN;
        end else if (sensor_door == DR_CLOSE) begin
          w_door  = DR_IDLE;
          w_state = S_IDLE;
        end
`else
        if (sensor_door == DR_CLOSE) begin
          w_door  = DR_IDLE;
          w_state = S_IDLE;
        end
`endif
      end
      default: begin
        w_state  = S_IDLE;
        w_engine = ENG_STOP;
        w_door   = DR_IDLE;
      end
    endcase
    w_req = (r_req | w_set) & ~w_clr;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_engine <= ENG_STOP;
      r_door   <= DR_IDLE;
      r_floor  <= '0;
      r_req    <= '0;
      r_dir_up <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state;
      r_engine <= w_engine;
      r_door   <= w_door;
      r_floor  <= w_floor;
      r_req    <= w_req;
      r_dir_up <= w_dir_up;
      r_cnt    <= w_cnt;
    end
  end

  assign engine   = r_engine;
  assign door     = r_door;
  assign floor    = r_floor;
  assign requests = r_req;

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Car controller for the elevator: latches floor-call buttons, decides direction, drives the `engine` and `door` commands into the elevator plant model, and consumes the plant's `sensor_up`, `sensor_down` and `sensor_door` feedback. It sits directly upstream of the plant and closes the loop: commands out, sensors back in. Service policy is single-sweep (SCAN): keep the current direction while calls remain ahead, otherwise reverse.

## Interface
- `BUTTONS_WIDTH`, 8: number of floors and button inputs.
- `FLOOR_W`, 3: width of `floor`; requires 2^FLOOR_W >= BUTTONS_WIDTH.
- `DOOR_HOLD`, 20: cycles the door stays fully open before closing; must be >= 1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `buttons`  in  BUTTONS_WIDTH  call requests, bit i = floor i, level-sampled every cycle.
- `sensor_up`  in  1  one-cycle pulse: car has moved up one floor.
- `sensor_down`  in  1  one-cycle pulse: car has moved down one floor.
- `sensor_door`  in  2  01 = fully open, 10 = fully closed, 00/11 = in motion.
- `engine`  out  2  00 = stop, 01 = up, 10 = down; 11 never driven.
- `door`  out  2  00 = idle, 01 = open, 10 = close; 11 never driven.
- `floor`  out  FLOOR_W  current floor index.
- `requests`  out  BUTTONS_WIDTH  pending calls.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, DOOR_HOLD, DOOR_CLOSE. All outputs are registered.
- Reset (reset = 0 at a rising edge): state IDLE, `engine` = 00, `door` = 00, `floor` = 0, `requests` = 0, direction = up, hold counter = 0. Reset applies from any state, including mid-move and mid-door.
- `requests[i]` is set by `buttons[i]` and cleared only on the door-fully-open event at floor i.
- IDLE, in priority order:
  - `requests[floor]` set: go to DOOR_OPEN.
  - Calls above and (direction = up or no calls below): go to MOVE_UP, direction = up.
  - Calls below: go to MOVE_DOWN, direction = down.
  - Otherwise stay in IDLE.
- MOVE_UP, `engine` = 01. On `sensor_up`: `floor` += 1. If `requests[new floor]` is set, `engine` = 00, `door` = 01, go to DOOR_OPEN. `sensor_up` at floor BUTTONS_WIDTH-1 is ignored (saturate) and forces `engine` = 00 and a return to IDLE. MOVE_DOWN mirrors this with `sensor_down`, 10, -1 and floor 0.
- Sensor pulses of the wrong direction, or outside the MOVE states, are ignored.
- DOOR_OPEN, `door` = 01. On `sensor_door` = 01: clear `requests[floor]`, `door` = 00, load the hold counter with DOOR_HOLD, go to DOOR_HOLD.
- DOOR_HOLD, `door` = 00, counter decrements. `buttons[floor]` high reloads the counter and is not latched. At counter = 1: `door` = 10, go to DOOR_CLOSE.
- DOOR_CLOSE, `door` = 10. On `sensor_door` = 10: `door` = 00, go to IDLE.
- Safety: `engine` != 00 only in MOVE states. MOVE states are entered only from IDLE, which is entered only after the door is confirmed closed. After reset, IDLE treats the door as closed.

## Timing
- `buttons[i]` sampled at edge N sets `requests[i]` after edge N. IDLE decides at edge N+1, so `engine` is nonzero after edge N+1 (2-cycle latency).
- Stop: `sensor_up` at edge M for a requested floor gives `floor` updated, `engine` = 00 and `door` = 01, all after edge M.
- `sensor_door` = 01 at edge K gives the request cleared and `door` = 00 after edge K. `door` = 10 appears DOOR_HOLD cycles later.
- `sensor_door` = 10 at edge C gives IDLE after edge C. A next move can start with `engine` set after edge C+1.
- A button and a clear of the same bit in the same cycle: the clear wins.
- Any number of buttons may be pressed in the same cycle; all are latched.

## Configuration
- `ELEVATOR_REOPEN_EN` defined: in DOOR_CLOSE, `buttons[floor]` high moves the FSM to DOOR_OPEN (`door` = 01) next cycle and the button is not latched.
- `ELEVATOR_REOPEN_EN` undefined: that button latches into `requests[floor]`. The door finishes closing, then IDLE reopens it.

## Test plan
- Reset: drive reset = 0 for 2 cycles from mid-MOVE_UP -> `engine` = 00, `door` = 00, `floor` = 0, `requests` = 0 after the first reset edge.
- Single call: `buttons` = 8'b0000_1000 for 1 cycle, plant pulses `sensor_up` every 10 cycles -> `engine` = 01, 3 pulses, `floor` = 3, `engine` = 00 and `door` = 01 in the same cycle, `requests` = 0 after `sensor_door` = 01.
- Sweep order: at floor 0, calls 2, 5, 1 -> stops at 1, 2, 5 in that order. A call to floor 0 made during the up-sweep is served after 5.
- Door hold: `sensor_door` = 01 at edge K -> `door` = 10 exactly DOOR_HOLD = 20 cycles later. A press of `buttons[floor]` during the hold delays the close by a full reload.
- Reopen: in DOOR_CLOSE, press `buttons[floor]` -> with `ELEVATOR_REOPEN_EN` defined, `door` = 01 next cycle. Without it, `door` stays 10, `requests[floor]` = 1, then IDLE leads to DOOR_OPEN.
- Boundaries: an extra `sensor_up` at floor 7 leaves `floor` = 7 and `engine` = 00. A call at the current floor in IDLE opens the door without moving. `engine` is never nonzero unless the last `sensor_door` was 10.
